// File: rtl/alu_8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_8_pkg
// Description : Shared types and constants for the alu_8 datapath ALU.
//               Holds the opcode enumeration and the bit positions of the
//               status flags inside the 4-bit flag vector.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_8_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOT  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SLA  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_ROL  = 4'd10,
        ALU_ROR  = 4'd11,
        ALU_PASS = 4'd12,
        ALU_SET  = 4'd13,
        ALU_RES  = 4'd14,
        ALU_BIT  = 4'd15
    } alu_op_e;

    // Bit positions inside the flags vector
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage : alu_8_pkg
`default_nettype wire

// File: rtl/alu_8_shifter.sv
`default_nettype none
// ============================================================================
// Module      : alu_8_shifter
// Description : Combinational shift/rotate unit for alu_8 (opcodes 6-11).
//               Shifts use the full 8-bit amount: any amount of 8 or more
//               shifts everything out. Rotates use the amount modulo 8.
// Ports       : a      - operand being shifted
//               b      - shift/rotate amount (full 8 bits)
//               op     - operation select
//               result - shifted/rotated value (0 for non-shift opcodes)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_8_shifter
    import alu_8_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  alu_op_e    op,
    output logic [7:0] result
);

    logic       w_big;
    logic [2:0] w_amt;
    logic [7:0] w_sll;
    logic [7:0] w_srl;
    logic [7:0] w_sra;
    logic [7:0] w_rol;
    logic [7:0] w_ror;

    // Any set bit above bit 2 means the amount is at least 8
    assign w_big = |b[7:3];
    assign w_amt = b[2:0];

    assign w_sll = a << w_amt;
    assign w_srl = a >> w_amt;
    assign w_sra = $signed(a) >>> w_amt;

    // With a zero amount the complementary shift is by 8 and contributes 0
    assign w_rol = (a << w_amt) | (a >> (4'd8 - {1'b0, w_amt}));
    assign w_ror = (a >> w_amt) | (a << (4'd8 - {1'b0, w_amt}));

    always_comb begin
        result = 8'h00;
        case (op)
            ALU_SLL, ALU_SLA: result = w_big ? 8'h00 : w_sll;
            ALU_SRL:          result = w_big ? 8'h00 : w_srl;
            ALU_SRA:          result = w_big ? {8{a[7]}} : w_sra;
            ALU_ROL:          result = w_rol;
            ALU_ROR:          result = w_ror;
            default:          result = 8'h00;
        endcase
    end

endmodule : alu_8_shifter
`default_nettype wire

// File: rtl/alu_8.sv
`default_nettype none
// ============================================================================
// Module      : alu_8
// Description : 8-bit registered ALU for the Z80 emulation datapath.
//               Result and S/Z/V/C flags are computed combinationally and
//               registered once per clock (1-cycle latency, no handshake).
//               Optional bit operations SET/RES/BIT are enabled by defining
//               the macro ALU_8_BIT_OPS_EN; otherwise opcodes 13-15 give 0x00.
// Ports       : clk    - rising-edge clock
//               rst_n  - synchronous reset, active low (clears out and flags)
//               a      - operand A
//               b      - operand B / shift, rotate or bit amount
//               opcode - operation select (alu_op_e encoding)
//               out    - registered result
//               flags  - registered flags {S, Z, V, C}
// Revision    : 1.0 - initial release
// ============================================================================
module alu_8
    import alu_8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] opcode,
    output logic [7:0] out,
    output logic [3:0] flags
);

    alu_op_e    w_op;
    logic [8:0] w_sum;
    logic [8:0] w_diff;
    logic [7:0] w_shift_res;
    logic [7:0] w_result;
    logic       w_c;
    logic       w_v;
    logic       w_z;
    logic [3:0] w_flags;
    logic [7:0] r_out;
    logic [3:0] r_flags;

    assign w_op   = alu_op_e'(opcode);

    // Ninth bit is carry out for ADD and borrow for SUB
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    alu_8_shifter u_shifter (
        .a      (a),
        .b      (b),
        .op     (w_op),
        .result (w_shift_res)
    );

`ifdef ALU_8_BIT_OPS_EN
    logic [7:0] w_bit_mask;
    assign w_bit_mask = 8'h01 << b[2:0];
`endif

    always_comb begin
        w_result = 8'h00;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (w_op)
            ALU_ADD: begin
                w_result = w_sum[7:0];
                w_c      = w_sum[8];
                // Overflow: like-signed operands, result sign differs
                w_v      = (a[7] == b[7]) && (w_sum[7] != a[7]);
            end
            ALU_SUB: begin
                w_result = w_diff[7:0];
                w_c      = w_diff[8];
                // Overflow: unlike-signed operands, result sign differs from a
                w_v      = (a[7] != b[7]) && (w_diff[7] != a[7]);
            end
            ALU_AND:  w_result = a & b;
            ALU_OR:   w_result = a | b;
            ALU_XOR:  w_result = a ^ b;
            ALU_NOT:  w_result = ~a;
            ALU_SLL, ALU_SRL, ALU_SLA, ALU_SRA, ALU_ROL, ALU_ROR:
                      w_result = w_shift_res;
            ALU_PASS: w_result = b;
`ifdef ALU_8_BIT_OPS_EN
            ALU_SET:  w_result = a | w_bit_mask;
            ALU_RES:  w_result = a & ~w_bit_mask;
            ALU_BIT:  w_result = 8'h00;
`else
            ALU_SET, ALU_RES, ALU_BIT:
                      w_result = 8'h00;
`endif
            default:  w_result = 8'h00;
        endcase

        w_z = (w_result == 8'h00);
`ifdef ALU_8_BIT_OPS_EN
        // BIT reports the tested bit through Z instead of the result
        if (w_op == ALU_BIT) begin
            w_z = ~a[b[2:0]];
        end
`endif

        w_flags         = 4'b0000;
        w_flags[FLAG_S] = w_result[7];
        w_flags[FLAG_Z] = w_z;
        w_flags[FLAG_V] = w_v;
        w_flags[FLAG_C] = w_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= 8'h00;
            r_flags <= 4'b0000;
        end else begin
            r_out   <= w_result;
            r_flags <= w_flags;
        end
    end

    assign out   = r_out;
    assign flags = r_flags;

endmodule : alu_8
`default_nettype wire

// File: tb/tb_alu_8.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_8
// Description : Self-checking testbench for alu_8. Table-driven vectors are
//               driven one per cycle; the expected result of each is pushed
//               to a scoreboard queue at drive time and popped/compared one
//               cycle later when the registered output is valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_8;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_out;
        logic [3:0] exp_flags;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] out;
        logic [3:0] flags;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] opcode;
    logic [7:0] out;
    logic [3:0] flags;

    int   checks   = 0;
    int   failures = 0;
    int   next_id  = 0;
    vec_t vecs[$];
    exp_t sb[$];

    alu_8 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .opcode (opcode),
        .out    (out),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add_vec(input logic [3:0] op, input logic [7:0] va,
                           input logic [7:0] vb, input logic [7:0] eo,
                           input logic [3:0] ef);
        vec_t v;
        v.op = op; v.a = va; v.b = vb; v.exp_out = eo; v.exp_flags = ef;
        vecs.push_back(v);
    endtask

    // Drive one operation at the falling edge and record what it must produce
    task automatic drive(input logic rn, input logic [3:0] op, input logic [7:0] va,
                         input logic [7:0] vb, input logic [7:0] eo,
                         input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        rst_n  = rn;
        opcode = op;
        a      = va;
        b      = vb;
        e.id    = next_id;
        e.out   = eo;
        e.flags = ef;
        next_id = next_id + 1;
        sb.push_back(e);
    endtask

    // Scoreboard checker: one expected entry per captured edge
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks = checks + 1;
            if (out !== e.out) begin
                failures = failures + 1;
                $display("FAIL out vec%0d: got %02h expected %02h", e.id, out, e.out);
            end
            checks = checks + 1;
            if (flags !== e.flags) begin
                failures = failures + 1;
                $display("FAIL flags vec%0d: got %04b expected %04b", e.id, flags, e.flags);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        opcode = 4'd0;
        a      = 8'h00;
        b      = 8'h00;

        // Flags are {S,Z,V,C}
        add_vec(4'd0,  8'h07, 8'h07, 8'h0E, 4'b0000); // ADD
        add_vec(4'd1,  8'h07, 8'h07, 8'h00, 4'b0100); // SUB -> zero
        add_vec(4'd2,  8'h0D, 8'h07, 8'h05, 4'b0000); // AND
        add_vec(4'd3,  8'hCB, 8'h2B, 8'hEB, 4'b1000); // OR
        add_vec(4'd4,  8'hFF, 8'h8A, 8'h75, 4'b0000); // XOR
        add_vec(4'd5,  8'h55, 8'h00, 8'hAA, 4'b1000); // NOT
        add_vec(4'd6,  8'h07, 8'd3,  8'h38, 4'b0000); // SLL
        add_vec(4'd6,  8'h0F, 8'd6,  8'hC0, 4'b1000);
        add_vec(4'd6,  8'h0F, 8'd9,  8'h00, 4'b0100);
        add_vec(4'd6,  8'hFF, 8'h80, 8'h00, 4'b0100); // only high amount bit set
        add_vec(4'd7,  8'hCA, 8'd3,  8'h19, 4'b0000); // SRL
        add_vec(4'd7,  8'hCA, 8'd8,  8'h00, 4'b0100);
        add_vec(4'd7,  8'hCA, 8'd0,  8'hCA, 4'b1000);
        add_vec(4'd8,  8'h07, 8'd3,  8'h38, 4'b0000); // SLA
        add_vec(4'd8,  8'h0F, 8'd6,  8'hC0, 4'b1000);
        add_vec(4'd8,  8'h0F, 8'd9,  8'h00, 4'b0100);
        add_vec(4'd9,  8'hCA, 8'd3,  8'hF9, 4'b1000); // SRA
        add_vec(4'd9,  8'h4A, 8'd3,  8'h09, 4'b0000);
        add_vec(4'd9,  8'hCA, 8'd8,  8'hFF, 4'b1000);
        add_vec(4'd9,  8'h4A, 8'd8,  8'h00, 4'b0100);
        add_vec(4'd10, 8'hCA, 8'd3,  8'h56, 4'b0000); // ROL
        add_vec(4'd10, 8'h80, 8'd10, 8'h02, 4'b0000);
        add_vec(4'd11, 8'h56, 8'd3,  8'hCA, 4'b1000); // ROR
        add_vec(4'd11, 8'h81, 8'd0,  8'h81, 4'b1000);
        add_vec(4'd12, 8'h11, 8'h3C, 8'h3C, 4'b0000); // PASS
        add_vec(4'd0,  8'hFF, 8'h01, 8'h00, 4'b0101); // ADD carry + zero
        add_vec(4'd0,  8'h7F, 8'h01, 8'h80, 4'b1010); // ADD overflow
        add_vec(4'd1,  8'h00, 8'h01, 8'hFF, 4'b1001); // SUB borrow
        add_vec(4'd1,  8'h80, 8'h01, 8'h7F, 4'b0010); // SUB overflow
        add_vec(4'd2,  8'hF0, 8'hFF, 8'hF0, 4'b1000); // AND clears C/V after arith
`ifdef ALU_8_BIT_OPS_EN
        add_vec(4'd13, 8'h07, 8'd7,  8'h87, 4'b1000); // SET
        add_vec(4'd13, 8'h07, 8'd15, 8'h87, 4'b1000); // only b[2:0] used
        add_vec(4'd14, 8'h07, 8'd1,  8'h05, 4'b0000); // RES
        add_vec(4'd15, 8'h07, 8'd3,  8'h00, 4'b0100); // BIT clear -> Z=1
        add_vec(4'd15, 8'h07, 8'd0,  8'h00, 4'b0000); // BIT set -> Z=0
`else
        add_vec(4'd13, 8'h07, 8'd7,  8'h00, 4'b0100);
        add_vec(4'd14, 8'h07, 8'd7,  8'h00, 4'b0100);
        add_vec(4'd15, 8'h07, 8'd7,  8'h00, 4'b0100);
`endif

        // Reset: held for one edge with an ADD presented
        drive(1'b0, 4'd0, 8'h07, 8'h07, 8'h00, 4'b0000);

        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].exp_out, vecs[i].exp_flags);
        end

        // Mid-stream reset overrides an ADD, then operation resumes
        drive(1'b1, 4'd0, 8'h7F, 8'h01, 8'h80, 4'b1010);
        drive(1'b0, 4'd0, 8'h07, 8'h07, 8'h00, 4'b0000);
        drive(1'b1, 4'd0, 8'h07, 8'h07, 8'h0E, 4'b0000);
        drive(1'b1, 4'd1, 8'h00, 8'h01, 8'hFF, 4'b1001);

        // Let the scoreboard drain, bounded
        for (int k = 0; k < 5 && sb.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_8
`default_nettype wire
